// File: rtl/mem_access_stage.sv
// mem_access_stage: memory-access pipeline stage between execute/address
// generation and write-back.
//   - Loads/stores go out on a ready/valid data-memory port.
//   - Non-memory ops pass straight through to the MEM latch.
//   - Upstream is stalled while an access is in flight.
//   - The MEM latch drives a forwarding bus.
//
// Handshake: a request transfers on any rising edge where dmem_req_valid
// and dmem_req_ready are both 1. While dmem_req_valid is high, the request
// fields follow the stalled (and therefore stable) upstream inputs. A load
// response is taken only in the cycle where dmem_resp_valid is 1 and the
// FSM is waiting in RESP; in any other state it is ignored.
//
// Optional feature: define MEM_MISALIGN_TRAP_EN to trap loads and stores
// whose address is not word aligned. A trapped op issues no request,
// completes in one cycle without writing a register, and sets the
// mem_misalign latch field.
module mem_access_stage #(
  parameter int DBITS     = 32,
  parameter int REGNOBITS = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 agex_valid,
  input  logic                 agex_is_ld,
  input  logic                 agex_is_st,
  input  logic [DBITS-1:0]     agex_aluout,
  input  logic [DBITS-1:0]     agex_stdata,
  input  logic [DBITS-1:0]     agex_pc,
  input  logic                 agex_wr_reg,
  input  logic [REGNOBITS-1:0] agex_wregno,
  output logic                 mem_stall,
  output logic                 dmem_req_valid,
  input  logic                 dmem_req_ready,
  output logic                 dmem_req_we,
  output logic [DBITS-1:0]     dmem_req_addr,
  output logic [DBITS-1:0]     dmem_req_wdata,
  input  logic                 dmem_resp_valid,
  input  logic [DBITS-1:0]     dmem_resp_rdata,
  output logic                 mem_valid,
  output logic [DBITS-1:0]     mem_pc,
  output logic                 mem_wr_reg,
  output logic [REGNOBITS-1:0] mem_wregno,
  output logic [DBITS-1:0]     mem_wdata,
  output logic                 fwd_valid,
  output logic [REGNOBITS-1:0] fwd_regno,
  output logic [DBITS-1:0]     fwd_data,
  output logic [1:0]           dbg_state
`ifdef MEM_MISALIGN_TRAP_EN
  ,
  output logic                 mem_misalign
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RESP = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic                   done;
  logic                   mem_op;
  logic                   issue;
  logic                   misaligned;
  logic [DBITS-1:0]       wdata_d;

  logic                   mem_valid_q;
  logic [DBITS-1:0]       mem_pc_q;
  logic                   mem_wr_reg_q;
  logic [REGNOBITS-1:0]   mem_wregno_q;
  logic [DBITS-1:0]       mem_wdata_q;
  logic                   mem_misalign_q;

  // Classify the incoming op; a misaligned access never reaches memory.
  always_comb begin
    mem_op = agex_is_ld | agex_is_st;
`ifdef MEM_MISALIGN_TRAP_EN
    misaligned = mem_op & (agex_aluout[1:0] != 2'b00);
`else
    misaligned = 1'b0;
`endif
    issue = agex_valid & mem_op & ~misaligned;
  end

  // Next state and the "op completes this cycle" strobe.
  always_comb begin
    state_d = state_q;
    done    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (issue) begin
          state_d = S_REQ;
        end else begin
          done = agex_valid;
        end
      end
      S_REQ: begin
        if (dmem_req_ready) begin
          // ld has priority over st when both are set
          if (agex_is_ld) begin
            state_d = S_RESP;
          end else begin
            done    = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
      S_RESP: begin
        if (dmem_resp_valid) begin
          done    = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Only a load can complete in RESP, so that is the only place load data is used.
  always_comb begin
    wdata_d = (state_q == S_RESP) ? dmem_resp_rdata : agex_aluout;
  end

  // FSM state and MEM latch; cycles that do not complete an op latch a bubble.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= S_IDLE;
      mem_valid_q    <= 1'b0;
      mem_pc_q       <= '0;
      mem_wr_reg_q   <= 1'b0;
      mem_wregno_q   <= '0;
      mem_wdata_q    <= '0;
      mem_misalign_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (done) begin
        mem_valid_q    <= 1'b1;
        mem_pc_q       <= agex_pc;
        mem_wr_reg_q   <= agex_wr_reg & ~misaligned;
        mem_wregno_q   <= agex_wregno;
        mem_wdata_q    <= wdata_d;
        mem_misalign_q <= misaligned;
      end else begin
        mem_valid_q    <= 1'b0;
        mem_pc_q       <= '0;
        mem_wr_reg_q   <= 1'b0;
        mem_wregno_q   <= '0;
        mem_wdata_q    <= '0;
        mem_misalign_q <= 1'b0;
      end
    end
  end

  // Request port, stall, latch outputs and forwarding bus.
  always_comb begin
    dmem_req_valid = (state_q == S_REQ);
    dmem_req_we    = agex_is_st & ~agex_is_ld;
    dmem_req_addr  = agex_aluout;
    dmem_req_wdata = agex_stdata;
    mem_stall      = agex_valid & mem_op & ~done;
    mem_valid      = mem_valid_q;
    mem_pc         = mem_pc_q;
    mem_wr_reg     = mem_wr_reg_q & mem_valid_q;
    mem_wregno     = mem_wregno_q;
    mem_wdata      = mem_wdata_q;
    fwd_valid      = mem_valid_q & mem_wr_reg_q;
    fwd_regno      = mem_wregno_q;
    fwd_data       = mem_wdata_q;
    dbg_state      = state_q;
  end

`ifdef MEM_MISALIGN_TRAP_EN
  assign mem_misalign = mem_misalign_q;
`else
  // The misalign field only leaves the block when the trap is built in.
  logic unused_misalign;
  assign unused_misalign = mem_misalign_q;
`endif

endmodule
